boot_stream_loader: RTL
=======================

BOOT_STREAM_LOADER -- requirements
Module: boot_stream_loader

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning instruction word width.
REQ-002 SHALL have parameter ADDR_W, default 8, meaning instruction memory address width.
REQ-003 SHALL have parameter BASE_ADDR, default 0, meaning first write address.
REQ-004 SHALL have port clk, input, 1 bit, meaning the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst, input, 1 bit, meaning reset; asynchronous, active-high.
REQ-006 SHALL have port start, input, 1 bit, meaning a one-cycle request to begin a load.
REQ-007 SHALL have port len, input, ADDR_W+1 bits, meaning the number of program words, sampled with start.
REQ-008 SHALL have port abort, input, 1 bit, meaning cancel the load in progress.
REQ-009 SHALL have port in_valid, input, 1 bit, meaning the stream word is valid.
REQ-010 SHALL have port in_data, input, DATA_W bits, meaning the stream word (program words, then one checksum word).
REQ-011 SHALL have port in_ready, output, 1 bit, meaning the loader accepts the stream word.
REQ-012 SHALL have port boot_up, output, 1 bit, meaning the core is held in boot mode.
REQ-013 SHALL have port boot_web, output, 1 bit, meaning instruction memory write enable, active-low.
REQ-014 SHALL have port boot_addr, output, ADDR_W bits, meaning instruction memory write address.
REQ-015 SHALL have port boot_datai, output, DATA_W bits, meaning instruction memory write data.
REQ-016 SHALL have port word_cnt, output, ADDR_W+1 bits, meaning the number of program words written so far.
REQ-017 SHALL have port done, output, 1 bit, meaning load completed with a good checksum (sticky).
REQ-018 SHALL have port err, output, 1 bit, meaning bad checksum or abort (sticky).

Function
REQ-019 SHALL implement states IDLE, LOAD, CHECK, DONE and ERR.
REQ-020 SHALL define handshake: a word transfers on a rising edge with in_valid=1 and in_ready=1; in_ready SHALL be 1 only in LOAD and CHECK.
REQ-021 On start in IDLE, DONE or ERR, SHALL do all of: latch len; clear word_cnt, checksum, done and err; set boot_up=1; go to LOAD, or to CHECK if len=0.
REQ-022 SHALL ignore start while in LOAD or CHECK.
REQ-023 For each word accepted in LOAD, the next cycle SHALL present boot_web=0, boot_datai=word and boot_addr=(BASE_ADDR+index) mod 2^ADDR_W for exactly one cycle; index runs from 0.
REQ-024 In every other cycle, SHALL hold boot_web=1 and keep the last boot_addr and boot_datai.
REQ-025 SHALL increment word_cnt and update checksum=(checksum+word) mod 2^DATA_W on each LOAD acceptance.
REQ-026 On the acceptance where word_cnt reaches len, SHALL move to CHECK.
REQ-027 SHALL allow back-to-back acceptance every cycle, and SHALL allow in_valid gaps of any length.
REQ-028 In CHECK, on acceptance, SHALL NOT write the checksum word to memory.
REQ-029 In CHECK, if in_data equals checksum, SHALL go to DONE with done=1; otherwise SHALL go to ERR with err=1.
REQ-030 In both DONE and ERR, boot_up SHALL go to 0 on the same edge as that transition.
REQ-031 abort=1 in LOAD or CHECK SHALL go to ERR on the next edge with err=1 and boot_up=0, taking priority over a simultaneous acceptance; that word SHALL NOT be written.
REQ-032 SHALL ignore abort in IDLE, DONE and ERR.
REQ-033 If len exceeds 2^ADDR_W, addresses SHALL wrap modulo 2^ADDR_W; no error is flagged.
REQ-034 All outputs SHALL be registered, except in_ready, which SHALL be decoded from state.

Reset
REQ-035 On rst=1, SHALL immediately force state IDLE, in_ready=0, boot_up=0, boot_web=1, boot_addr=0, boot_datai=0, word_cnt=0, checksum=0, done=0 and err=0, including mid-load.
REQ-036 After rst falls, SHALL require a new start before any load.

Verification
REQ-037 SHALL cover: start with len=45, then 45 back-to-back words w_i=i+1, then checksum 1035 -> 45 single-cycle boot_web=0 pulses at addresses 0..44 carrying data 1..45, then done=1 and boot_up=0.
REQ-038 SHALL cover: the same stream with checksum 1034 -> no write on the checksum word, err=1, done=0, word_cnt=45.
REQ-039 SHALL cover: BASE_ADDR=250, ADDR_W=8, len=10 -> writes at addresses 250..255 then 0..3.
REQ-040 SHALL cover: abort asserted together with the 5th valid word -> only 4 writes, err=1 on the next edge; a following start with len=0 and checksum 0 -> done=1.
REQ-041 SHALL cover: rst pulsed after 20 words, then start with len=3 -> outputs equal reset values during rst; addresses restart at BASE_ADDR.
REQ-042 SHALL cover: random in_valid gaps plus a start pulse during LOAD -> write sequence identical to the gap-free case and start has no effect.

Source files
------------

// File: rtl/boot_stream_loader.sv
// ============================================================================
// Module      : boot_stream_loader
// Description : Streams a program image into instruction memory while holding
//               the core in boot mode, then verifies a trailing checksum word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module boot_stream_loader #(
    parameter int          DATA_W    = 32,
    parameter int          ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              boot_up,
    output logic              boot_web,
    output logic [ADDR_W-1:0] boot_addr,
    output logic [DATA_W-1:0] boot_datai,
    output logic [ADDR_W:0]   word_cnt,
    output logic              done,
    output logic              err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_CHECK = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    localparam logic [ADDR_W-1:0] C_BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   C_CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   C_CNT_ZERO = '0;

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   r_word_cnt;
    logic [DATA_W-1:0] r_checksum;
    logic [ADDR_W-1:0] r_waddr;
    logic              r_boot_up;
    logic              r_boot_web;
    logic [ADDR_W-1:0] r_boot_addr;
    logic [DATA_W-1:0] r_boot_datai;
    logic              r_done;
    logic              r_err;

    logic              w_in_ready;
    logic              w_accept;
    logic              w_start_ok;
    logic [ADDR_W:0]   w_cnt_nxt;
    logic              w_last;
    logic              w_sum_ok;

    assign w_in_ready = (r_state == S_LOAD) || (r_state == S_CHECK);
    assign w_accept   = in_valid && w_in_ready;
    assign w_start_ok = start && !w_in_ready;
    assign w_cnt_nxt  = r_word_cnt + C_CNT_ONE;
    assign w_last     = (w_cnt_nxt == r_len);
    assign w_sum_ok   = (in_data == r_checksum);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (w_start_ok) begin
                    w_state_nxt = (len == C_CNT_ZERO) ? S_CHECK : S_LOAD;
                end
            end
            S_LOAD: begin
                if (abort) begin
                    w_state_nxt = S_ERR;
                end else if (w_accept && w_last) begin
                    w_state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                if (abort) begin
                    w_state_nxt = S_ERR;
                end else if (w_accept) begin
                    w_state_nxt = w_sum_ok ? S_DONE : S_ERR;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Write strobe is a single-cycle pulse; address/data hold their last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len        <= '0;
            r_word_cnt   <= '0;
            r_checksum   <= '0;
            r_waddr      <= C_BASE;
            r_boot_up    <= 1'b0;
            r_boot_web   <= 1'b1;
            r_boot_addr  <= '0;
            r_boot_datai <= '0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_boot_web <= 1'b1;
            if (w_start_ok) begin
                r_len      <= len;
                r_word_cnt <= '0;
                r_checksum <= '0;
                r_waddr    <= C_BASE;
                r_done     <= 1'b0;
                r_err      <= 1'b0;
                r_boot_up  <= 1'b1;
            end else if (w_in_ready && abort) begin
                r_err     <= 1'b1;
                r_boot_up <= 1'b0;
            end else if (w_accept && (r_state == S_LOAD)) begin
                r_boot_web   <= 1'b0;
                r_boot_addr  <= r_waddr;
                r_boot_datai <= in_data;
                r_waddr      <= r_waddr + 1'b1;
                r_word_cnt   <= w_cnt_nxt;
                r_checksum   <= r_checksum + in_data;
            end else if (w_accept && (r_state == S_CHECK)) begin
                r_done    <= w_sum_ok;
                r_err     <= !w_sum_ok;
                r_boot_up <= 1'b0;
            end
        end
    end

    assign in_ready   = w_in_ready;
    assign boot_up    = r_boot_up;
    assign boot_web   = r_boot_web;
    assign boot_addr  = r_boot_addr;
    assign boot_datai = r_boot_datai;
    assign word_cnt   = r_word_cnt;
    assign done       = r_done;
    assign err        = r_err;

endmodule

`default_nettype wire
